ball_motion: RTL

Ball kinematics engine for the 640x400 pong playfield. Owns the ball's `XCord`/`YCord` and its direction and speed, and sequences serve, movement and miss. It consumes the 3-bit collision code from the collision checker and produces the coordinates that checker evaluates, so it closes the ball loop directly downstream of it. All position updates happen on a one-cycle frame tick.

---
 rtl/ball_motion_if.sv | 24 ++
 rtl/ball_motion.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_if.sv
// Ball motion bus: frame tick, collision code and control in,
// ball position and status out.
interface ball_motion_if;
    logic       FrameTick;
    logic [2:0] ColIn;
    logic       Serve;
    logic       Pause;
    logic [9:0] XCord;
    logic [9:0] YCord;
    logic       Moving;
    logic       Miss;
    logic [7:0] HitCount;
    logic [3:0] Speed;

    modport master (
        output FrameTick, ColIn, Serve, Pause,
        input  XCord, YCord, Moving, Miss, HitCount, Speed
    );

    modport slave (
        input  FrameTick, ColIn, Serve, Pause,
        output XCord, YCord, Moving, Miss, HitCount, Speed
    );
endinterface

// File: rtl/ball_motion.sv
// Pong ball kinematics: serve countdown, per-frame stepping,
// reflection from latched collision flags, and miss detection.
module ball_motion #(
    parameter int START_X      = 320,
    parameter int START_Y      = 200,
    parameter int Y_MAX        = 400,
    parameter int SERVE_FRAMES = 60,
    parameter int INIT_SPEED   = 2,
    parameter int MAX_SPEED    = 7,
    parameter int SPEEDUP_HITS = 4
) (
    input logic          Clk,
    input logic          Rst_n,
    ball_motion_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE, MOVE} state_t;

    localparam logic [9:0]  SX       = 10'(START_X);
    localparam logic [9:0]  SY       = 10'(START_Y);
    localparam logic [9:0]  YMAX     = 10'(Y_MAX);
    localparam logic [10:0] YMAX11   = 11'(Y_MAX);
    localparam logic [7:0]  SRV_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [3:0]  INIT_SPD = 4'(INIT_SPEED);
    localparam logic [3:0]  MAX_SPD  = 4'(MAX_SPEED);

    // flag bit positions
    localparam int FP = 0;
    localparam int FN = 1;
    localparam int FW = 2;
    localparam int FC = 3;
    localparam int FF = 4;

    state_t      state, stateN;
    logic [9:0]  xCord, xCordN;
    logic [9:0]  yCord, yCordN;
    logic        dirX, dirXN;
    logic        dirY, dirYN;
    logic [3:0]  speed, speedN;
    logic [7:0]  hitCnt, hitCntN;
    logic        miss, missN;
    logic [4:0]  flags, flagsN;
    logic [7:0]  cnt, cntN;
    logic [4:0]  colDec;
    logic [4:0]  eff;
    logic [10:0] sumX, sumY;
    logic [7:0]  hitInc;

    always_comb begin
        colDec = '0;
        case (bus.ColIn)
            3'b001:  colDec[FP] = 1'b1;
            3'b011:  colDec[FN] = 1'b1;
            3'b100:  colDec[FW] = 1'b1;
            3'b010:  colDec[FC] = 1'b1;
            3'b110:  colDec[FF] = 1'b1;
            default: colDec = '0;
        endcase
    end

    always_comb begin
        stateN  = state;
        xCordN  = xCord;
        yCordN  = yCord;
        dirXN   = dirX;
        dirYN   = dirY;
        speedN  = speed;
        hitCntN = hitCnt;
        missN   = 1'b0;
        flagsN  = flags;
        cntN    = cnt;
        eff     = flags | colDec;
        sumX    = '0;
        sumY    = '0;
        hitInc  = hitCnt;
        unique case (state)
            IDLE: begin
                xCordN = SX;
                yCordN = SY;
                flagsN = '0;
                cntN   = '0;
                if (bus.Serve) begin
                    stateN  = SERVE;
                    speedN  = INIT_SPD;
                    hitCntN = '0;
                    dirXN   = 1'b1;
                    dirYN   = ~dirY;
                end
            end
            SERVE: begin
                flagsN = '0;
                if (bus.FrameTick && !bus.Pause) begin
                    if (cnt == SRV_LAST) begin
                        stateN = MOVE;
                        cntN   = '0;
                    end else begin
                        cntN = cnt + 8'd1;
                    end
                end
            end
            MOVE: begin
                if (!bus.Pause) begin
                    flagsN = eff;
                    if (bus.FrameTick) begin
                        flagsN = '0;
                        if (eff[FN]) begin
                            stateN = IDLE;
                            xCordN = SX;
                            yCordN = SY;
                            missN  = 1'b1;
                        end else begin
                            // P and W are mutually exclusive on pre-tick DirX
                            if (eff[FP] && dirX) begin
                                dirXN = 1'b0;
                                if (hitCnt != 8'hFF)
                                    hitInc = hitCnt + 8'd1;
                                hitCntN = hitInc;
                                if ((32'(hitInc) % SPEEDUP_HITS) == 0
                                    && speed < MAX_SPD)
                                    speedN = speed + 4'd1;
                            end
                            if (eff[FW] && !dirX)
                                dirXN = 1'b1;
                            if (eff[FC] && !dirY)
                                dirYN = 1'b1;
                            if (eff[FF] && dirY)
                                dirYN = 1'b0;

                            if (dirXN) begin
                                sumX   = {1'b0, xCord} + {7'b0, speed};
                                xCordN = sumX[10] ? 10'h3FF : sumX[9:0];
                            end else if (xCord < {6'b0, speed}) begin
                                xCordN = '0;
                                dirXN  = 1'b1;
                            end else begin
                                xCordN = xCord - {6'b0, speed};
                            end

                            if (dirYN) begin
                                sumY = {1'b0, yCord} + {7'b0, speed};
                                if (sumY > YMAX11) begin
                                    yCordN = YMAX;
                                    dirYN  = 1'b0;
                                end else begin
                                    yCordN = sumY[9:0];
                                end
                            end else if (yCord < {6'b0, speed}) begin
                                yCordN = '0;
                                dirYN  = 1'b1;
                            end else begin
                                yCordN = yCord - {6'b0, speed};
                            end
                        end
                    end
                end
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state  <= IDLE;
            xCord  <= SX;
            yCord  <= SY;
            dirX   <= 1'b1;
            dirY   <= 1'b1;
            speed  <= INIT_SPD;
            hitCnt <= '0;
            miss   <= 1'b0;
            flags  <= '0;
            cnt    <= '0;
        end else begin
            state  <= stateN;
            xCord  <= xCordN;
            yCord  <= yCordN;
            dirX   <= dirXN;
            dirY   <= dirYN;
            speed  <= speedN;
            hitCnt <= hitCntN;
            miss   <= missN;
            flags  <= flagsN;
            cnt    <= cntN;
        end
    end

    assign bus.XCord    = xCord;
    assign bus.YCord    = yCord;
    assign bus.Moving   = (state == MOVE);
    assign bus.Miss     = miss;
    assign bus.HitCount = hitCnt;
    assign bus.Speed    = speed;
endmodule
